// File: rtl/pe_div_share.sv
// Shared restoring divider with round-robin grant across numReq PEs.
// Build option: define DIV_SIGNED_EN for two's-complement operands.
module pe_div_share #(
    parameter int numReq    = 8,
    parameter int logNumReq = 3,
    parameter int dataLen   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [numReq-1:0]           req,
    input  logic [numReq*dataLen-1:0]   req_op1,
    input  logic [numReq*dataLen-1:0]   req_op2,
    output logic [numReq-1:0]           gnt,
    output logic [numReq-1:0]           rsp_valid,
    output logic [dataLen-1:0]          rsp_data,
    output logic                        rsp_dz,
    output logic                        busy
);

    localparam int CW = (dataLen > 1) ? $clog2(dataLen) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [logNumReq-1:0] rr_ptr;
    logic [logNumReq-1:0] id;
    logic [logNumReq-1:0] pick;
    logic [logNumReq-1:0] cand;
    logic                 found;
    int                   j;
    logic [CW-1:0]        cnt;
    logic [dataLen-1:0]   quo;
    logic [dataLen-1:0]   dvs;
    logic [dataLen-1:0]   rem;
    logic                 dz;
    logic [dataLen-1:0]   op1_sel;
    logic [dataLen-1:0]   op2_sel;
    logic [dataLen-1:0]   abs1;
    logic [dataLen-1:0]   abs2;
    logic [dataLen:0]     rem_sh;
    logic                 ge;
    logic [dataLen-1:0]   rem_nx;
    logic [dataLen-1:0]   q_nx;
    logic [dataLen-1:0]   res;
`ifdef DIV_SIGNED_EN
    logic                 neg;
    logic                 dvd_neg;
`endif

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        j     = 0;
        for (int i = 0; i < numReq; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= numReq) j = j - numReq;
            cand = logNumReq'(j);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign op1_sel = req_op1[pick*dataLen +: dataLen];
    assign op2_sel = req_op2[pick*dataLen +: dataLen];

`ifdef DIV_SIGNED_EN
    assign abs1 = op1_sel[dataLen-1] ? -op1_sel : op1_sel;
    assign abs2 = op2_sel[dataLen-1] ? -op2_sel : op2_sel;
`else
    assign abs1 = op1_sel;
    assign abs2 = op2_sel;
`endif

    assign rem_sh = {rem, quo[dataLen-1]};
    assign ge     = rem_sh >= {1'b0, dvs};
    assign rem_nx = ge ? rem_sh[dataLen-1:0] - dvs : rem_sh[dataLen-1:0];
    assign q_nx   = {quo[dataLen-2:0], ge};

    always_comb begin
        res = q_nx;
`ifdef DIV_SIGNED_EN
        if (dz)
            res = dvd_neg ? {1'b1, {(dataLen-1){1'b0}}}
                          : {1'b0, {(dataLen-1){1'b1}}};
        else if (neg)
            res = -q_nx;
        else if (q_nx[dataLen-1])
            res = {1'b0, {(dataLen-1){1'b1}}};
`else
        if (dz)
            res = '1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id        <= '0;
            cnt       <= '0;
            quo       <= '0;
            dvs       <= '0;
            rem       <= '0;
            dz        <= 1'b0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_dz    <= 1'b0;
            busy      <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg       <= 1'b0;
            dvd_neg   <= 1'b0;
`endif
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        id     <= pick;
                        gnt    <= numReq'(1) << pick;
                        quo    <= abs1;
                        dvs    <= abs2;
                        rem    <= '0;
                        dz     <= (op2_sel == '0);
                        cnt    <= CW'(dataLen - 1);
                        busy   <= 1'b1;
                        rr_ptr <= (pick == logNumReq'(numReq - 1)) ?
                                  '0 : pick + 1'b1;
                        state  <= CALC;
`ifdef DIV_SIGNED_EN
                        neg     <= op1_sel[dataLen-1] ^ op2_sel[dataLen-1];
                        dvd_neg <= op1_sel[dataLen-1];
`endif
                    end
                end
                CALC: begin
                    quo <= q_nx;
                    rem <= rem_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        rsp_valid <= numReq'(1) << id;
                        rsp_data  <= res;
                        rsp_dz    <= dz;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    rsp_data <= '0;
                    rsp_dz   <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_div_share.sv
// Directed bench for pe_div_share: timing, arbitration, div-by-zero, reset.
// Signed vectors run only when DIV_SIGNED_EN is defined.
module tb_pe_div_share;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    req;
    logic [127:0]  req_op1;
    logic [127:0]  req_op2;
    logic [7:0]    gnt;
    logic [7:0]    rsp_valid;
    logic [15:0]   rsp_data;
    logic          rsp_dz;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] qexp [8] = '{16'd33, 16'd50, 16'd60, 16'd66,
                              16'd71, 16'd75, 16'd77, 16'd80};

    pe_div_share dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_dz    (rsp_dz),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] a,
                          input logic [15:0] b);
        req_op1[i*16 +: 16] = a;
        req_op2[i*16 +: 16] = b;
    endtask

    task automatic run_one(input string tag, input int i,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] q, input logic z);
        set_op(i, a, b);
        req = 8'(32'(1) << i);
        tick(1);
        chk({tag, "_gnt"}, 32'(gnt), 32'(1) << i);
        req = '0;
        tick(16);
        chk({tag, "_vld"}, 32'(rsp_valid), 32'(1) << i);
        chk({tag, "_q"}, 32'(rsp_data), 32'(q));
        chk({tag, "_dz"}, 32'(rsp_dz), 32'(z));
        tick(1);
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        req_op1 = '0;
        req_op2 = '0;
        tick(2);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_vld", 32'(rsp_valid), 0);
        chk("rst_data", 32'(rsp_data), 0);
        chk("rst_dz", 32'(rsp_dz), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick(1);

        // Single request: exact latency and busy window.
        set_op(2, 16'd100, 16'd7);
        req = 8'b0000_0100;
        tick(1);
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_busy_g", 32'(busy), 1);
        req = '0;
        tick(1);
        chk("single_gnt_pulse", 32'(gnt), 0);
        for (int c = 1; c < 16; c++) begin
            chk("single_early_vld", 32'(rsp_valid), 0);
            chk("single_busy", 32'(busy), 1);
            tick(1);
        end
        chk("single_vld", 32'(rsp_valid), 32'h4);
        chk("single_q", 32'(rsp_data), 14);
        chk("single_dz", 32'(rsp_dz), 0);
        chk("single_busy_done", 32'(busy), 1);
        tick(1);
        chk("single_vld_pulse", 32'(rsp_valid), 0);
        chk("single_busy_idle", 32'(busy), 0);

        // Collision right after reset: rr_ptr must restart at 0.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        set_op(0, 16'd50, 16'd5);
        set_op(3, 16'd1000, 16'd3);
        req = 8'b0000_1001;
        tick(1);
        chk("coll_gnt0", 32'(gnt), 32'h1);
        req = 8'b0000_1000;
        tick(16);
        chk("coll_vld0", 32'(rsp_valid), 32'h1);
        chk("coll_q0", 32'(rsp_data), 10);
        tick(1);
        chk("coll_gap", 32'(gnt), 0);
        tick(1);
        chk("coll_gnt3", 32'(gnt), 32'h8);
        req = '0;
        tick(16);
        chk("coll_vld3", 32'(rsp_valid), 32'h8);
        chk("coll_q3", 32'(rsp_data), 333);
        tick(1);

`ifdef DIV_SIGNED_EN
        run_one("dz", 4, 16'd5, 16'd0, 16'h7FFF, 1'b1);
        run_one("sneg", 5, 16'hFF9C, 16'd7, 16'hFFF2, 1'b0);
        run_one("sovf", 6, 16'h8000, 16'hFFFF, 16'h7FFF, 1'b0);
        run_one("sdz", 7, 16'hFFFB, 16'h0000, 16'h8000, 1'b1);
`else
        run_one("dz", 4, 16'd5, 16'd0, 16'hFFFF, 1'b1);
`endif

        // Reset during CALC abandons the division.
        set_op(1, 16'd9, 16'd3);
        req = 8'b0000_0010;
        tick(1);
        chk("mid_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick(5);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_vld", 32'(rsp_valid), 0);
        chk("mid_rst_data", 32'(rsp_data), 0);
        chk("mid_rst_dz", 32'(rsp_dz), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        tick(2);
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick(1);
            chk("mid_no_vld", 32'(rsp_valid), 0);
        end
        run_one("mid_req5", 5, 16'd81, 16'd9, 16'd9, 1'b0);
        set_op(7, 16'd70, 16'd7);
        req = 8'b1000_0010;
        tick(1);
        chk("mid_rr6", 32'(gnt), 32'h80);
        req = 8'b0000_0010;
        tick(16);
        chk("mid_vld7", 32'(rsp_valid), 32'h80);
        chk("mid_q7", 32'(rsp_data), 10);
        tick(2);
        chk("mid_gnt1", 32'(gnt), 32'h2);
        req = '0;
        tick(16);
        chk("mid_q1", 32'(rsp_data), 3);
        tick(1);

        // Fairness with every PE requesting continuously.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++)
            set_op(i, 16'((i + 1) * 100), 16'(i + 3));
        req = 8'hFF;
        tick(1);
        chk("fair_gnt0", 32'(gnt), 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick(16);
            chk("fair_vld", 32'(rsp_valid), 32'(1) << i);
            chk("fair_q", 32'(rsp_data), 32'(qexp[i]));
            tick(2);
            chk("fair_gnt", 32'(gnt), 32'(1) << ((i + 1) % 8));
        end
        req = '0;
        tick(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
